// File: rtl/lcd_pkg.sv
// Shared types and constants for the PCD8544 (Nokia 5110) LCD sequencer.
// Contents: FSM state enum, command bytes, framebuffer size, counter widths,
// and seq_byte(), which maps a sequence index to the command byte it sends.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      ISSUE,
      WAIT,
      IDLE,
      FETCH,
      DONE
   } state_t;

   localparam logic [7:0] CMD_FUNC_EXT    = 8'h21;
   localparam logic [7:0] CMD_FUNC_BASIC  = 8'h20;
   localparam logic [7:0] CMD_DISP_NORMAL = 8'h0C;
   localparam logic [7:0] CMD_SET_X0      = 8'h80;
   localparam logic [7:0] CMD_SET_Y0      = 8'h40;

   localparam int unsigned FB_BYTES = 504;
   localparam int unsigned ADDR_W   = 9;
   localparam int unsigned SEQ_W    = 3;

   // Sequence indices that change the flow of the FSM.
   localparam logic [SEQ_W-1:0] SEQ_LAST_INIT = SEQ_W'(5);
   localparam logic [SEQ_W-1:0] SEQ_SET_X     = SEQ_W'(6);
   localparam logic [SEQ_W-1:0] SEQ_SET_Y     = SEQ_W'(7);

   // Command byte for each sequence index: init (0..5), then address set (6..7).
   function automatic logic [7:0] seq_byte(input logic [SEQ_W-1:0] idx,
                                           input logic [7:0]       vop,
                                           input logic [7:0]       tempc,
                                           input logic [7:0]       bias);
      logic [7:0] b;
      b = CMD_FUNC_EXT;
      case (idx)
         SEQ_W'(0): b = CMD_FUNC_EXT;
         SEQ_W'(1): b = vop;
         SEQ_W'(2): b = tempc;
         SEQ_W'(3): b = bias;
         SEQ_W'(4): b = CMD_FUNC_BASIC;
         SEQ_W'(5): b = CMD_DISP_NORMAL;
         SEQ_W'(6): b = CMD_SET_X0;
         default:   b = CMD_SET_Y0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_controller.sv
// Sequencer for a PCD8544 LCD behind an SPI byte serializer.
// After reset: idle RST_WAIT cycles, send the init commands, then go idle.
// On refresh (or always, when CONTINUOUS): send X/Y address 0, then stream
// the 504 framebuffer bytes read from an external synchronous memory.
// Ports:
//   clk, nrst       clock, asynchronous active-low reset
//   refresh         frame request, sampled only while idle
//   busy            high whenever not idle
//   frame_done      one-cycle pulse after the last data byte is accepted
//   fb_addr/fb_rdata frame memory read port (data one cycle after address)
//   spi_ready       serializer ready
//   spi_enable      one-cycle byte strobe; spi_data/spi_mode valid with it
//   spi_mode        1 = command, 0 = data
module lcd_controller
   import lcd_pkg::*;
#(
   parameter int unsigned RST_WAIT   = 1000,
   parameter logic [7:0]  VOP        = 8'hB1,
   parameter logic [7:0]  TEMPC      = 8'h04,
   parameter logic [7:0]  BIAS       = 8'h14,
   parameter bit          CONTINUOUS = 1'b0
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              refresh,
   output logic              busy,
   output logic              frame_done,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [7:0]        fb_rdata,
   input  logic              spi_ready,
   output logic              spi_enable,
   output logic [7:0]        spi_data,
   output logic              spi_mode
);

   localparam int unsigned        CNT_W     = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RST_WAIT - 1);
   localparam logic [ADDR_W-1:0]  LAST_BYTE = ADDR_W'(FB_BYTES - 1);

   state_t             state, state_d;
   logic [CNT_W-1:0]   dly_cnt, dly_cnt_d;
   logic [ADDR_W-1:0]  byte_cnt, byte_cnt_d;
   logic [ADDR_W-1:0]  fb_addr_d;
   logic [SEQ_W-1:0]   seq_idx, seq_idx_d;
   logic               wait_first, wait_first_d;
   logic [7:0]         spi_data_d;
   logic               spi_mode_d;

   // State and registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= PWR_WAIT;
         dly_cnt    <= '0;
         byte_cnt   <= '0;
         seq_idx    <= '0;
         wait_first <= 1'b0;
         fb_addr    <= '0;
         spi_data   <= 8'h00;
         spi_mode   <= 1'b1;
         spi_enable <= 1'b0;
         busy       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         dly_cnt    <= dly_cnt_d;
         byte_cnt   <= byte_cnt_d;
         seq_idx    <= seq_idx_d;
         wait_first <= wait_first_d;
         fb_addr    <= fb_addr_d;
         spi_data   <= spi_data_d;
         spi_mode   <= spi_mode_d;
         spi_enable <= (state_d == ISSUE);
         busy       <= (state_d != IDLE);
         frame_done <= (state_d == DONE);
      end
   end

   // Next-state logic. spi_data/spi_mode are loaded only on entry to ISSUE,
   // so they stay stable through the following WAIT. fb_addr runs one byte
   // ahead of the byte being sent, so the memory output is already valid when
   // FETCH registers it.
   always_comb begin
      state_d      = state;
      dly_cnt_d    = dly_cnt;
      byte_cnt_d   = byte_cnt;
      seq_idx_d    = seq_idx;
      fb_addr_d    = fb_addr;
      spi_data_d   = spi_data;
      spi_mode_d   = spi_mode;
      wait_first_d = 1'b0;

      unique case (state)
         PWR_WAIT: begin
            if (dly_cnt == CNT_LAST) begin
               state_d    = ISSUE;
               seq_idx_d  = '0;
               spi_data_d = seq_byte(SEQ_W'(0), VOP, TEMPC, BIAS);
               spi_mode_d = 1'b1;
            end else begin
               dly_cnt_d = dly_cnt + CNT_W'(1);
            end
         end

         ISSUE: begin
            state_d      = WAIT;
            wait_first_d = 1'b1;
         end

         // The first WAIT cycle ignores spi_ready: the serializer has not yet
         // had time to drop it after the strobe.
         WAIT: begin
            if (spi_ready && !wait_first) begin
               if (spi_mode) begin
                  if (seq_idx == SEQ_LAST_INIT) begin
                     state_d = IDLE;
                  end else if (seq_idx == SEQ_SET_Y) begin
                     state_d    = FETCH;
                     byte_cnt_d = '0;
                  end else begin
                     state_d    = ISSUE;
                     seq_idx_d  = seq_idx + SEQ_W'(1);
                     spi_data_d = seq_byte(seq_idx + SEQ_W'(1), VOP, TEMPC, BIAS);
                     spi_mode_d = 1'b1;
                  end
               end else if (byte_cnt == LAST_BYTE) begin
                  state_d = DONE;
               end else begin
                  state_d    = FETCH;
                  byte_cnt_d = byte_cnt + ADDR_W'(1);
               end
            end
         end

         IDLE: begin
            if (refresh || CONTINUOUS) begin
               state_d    = ISSUE;
               seq_idx_d  = SEQ_SET_X;
               spi_data_d = seq_byte(SEQ_SET_X, VOP, TEMPC, BIAS);
               spi_mode_d = 1'b1;
               fb_addr_d  = '0;
            end
         end

         FETCH: begin
            state_d    = ISSUE;
            spi_data_d = fb_rdata;
            spi_mode_d = 1'b0;
            fb_addr_d  = (byte_cnt == LAST_BYTE) ? byte_cnt : byte_cnt + ADDR_W'(1);
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = PWR_WAIT;
         end
      endcase
   end

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller: a serializer model logs every strobed byte, and
// the expected byte streams are built from the command list and the memory
// contents. A second instance runs with CONTINUOUS=1.
module tb_lcd_controller;

   typedef logic [8:0] ent_t;           // {spi_mode, spi_data}
   typedef ent_t       ent_q_t[$];

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance under directed test
   logic       nrst, refresh, busy, frame_done, spi_ready, spi_enable, spi_mode;
   logic [8:0] fb_addr;
   logic [7:0] fb_rdata, spi_data;
   logic [7:0] mem [0:511];

   // Continuous-mode instance
   logic       c_nrst, c_busy, c_done, c_ready, c_enable, c_mode;
   logic [8:0] c_addr;
   logic [7:0] c_rdata, c_data;
   logic [7:0] c_mem [0:511];

   lcd_controller #(.RST_WAIT(10), .CONTINUOUS(1'b0)) dut (
      .clk(clk), .nrst(nrst), .refresh(refresh), .busy(busy),
      .frame_done(frame_done), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
      .spi_ready(spi_ready), .spi_enable(spi_enable), .spi_data(spi_data),
      .spi_mode(spi_mode));

   lcd_controller #(.RST_WAIT(10), .CONTINUOUS(1'b1)) dut_c (
      .clk(clk), .nrst(c_nrst), .refresh(1'b0), .busy(c_busy),
      .frame_done(c_done), .fb_addr(c_addr), .fb_rdata(c_rdata),
      .spi_ready(c_ready), .spi_enable(c_enable), .spi_data(c_data),
      .spi_mode(c_mode));

   // Synchronous frame memories
   always @(posedge clk) fb_rdata <= mem[fb_addr];
   always @(posedge clk) c_rdata  <= c_mem[c_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Serializer model and monitor for the directed instance
   int     s_cnt = 0, lat = 9, override = 0, en_gap = 0, max_gap = 0, fd_cnt = 0;
   bit     rand_lat = 1'b0, prev_en = 1'b0, unstable = 1'b0, addr_track = 1'b0;
   ent_t   cap = '0;
   ent_q_t log_q;
   logic [8:0] addr_q[$];

   always @(negedge clk) begin
      if (!nrst) begin
         s_cnt = 0; spi_ready = 1'b1; prev_en = 1'b0;
      end else begin
         if (spi_enable) begin
            check("en_legal", 32'((s_cnt == 0) && !prev_en), 32'd1);
            log_q.push_back({spi_mode, spi_data});
            cap = {spi_mode, spi_data};
            unstable = 1'b0;
            if (en_gap > max_gap) max_gap = en_gap;
            en_gap = 0;
            if (override > 0) begin
               s_cnt = override; override = 0;
            end else begin
               s_cnt = rand_lat ? int'($urandom_range(9, 2)) : lat;
            end
            spi_ready = 1'b0;
         end else if (s_cnt > 0) begin
            if ({spi_mode, spi_data} !== cap) unstable = 1'b1;
            s_cnt--;
            if (s_cnt == 0) begin
               spi_ready = 1'b1;
               check("data_stable", 32'(unstable), 32'd0);
            end
         end
         en_gap++;
         prev_en = spi_enable;
         if (frame_done) fd_cnt++;
         if (addr_track && ((addr_q.size() == 0) ? (fb_addr == 9'd0) : (fb_addr != addr_q[$])))
            addr_q.push_back(fb_addr);
      end
   end

   // Serializer model and monitor for the continuous instance
   int     c_cnt = 0;
   ent_q_t c_log;
   int     c_fd_at[$];

   always @(negedge clk) begin
      if (!c_nrst) begin
         c_cnt = 0; c_ready = 1'b1;
      end else begin
         if (c_enable) begin
            c_log.push_back({c_mode, c_data});
            c_cnt = 4; c_ready = 1'b0;
         end else if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0) c_ready = 1'b1;
         end
         if (c_done) c_fd_at.push_back(c_log.size());
      end
   end

   // Reference streams
   task automatic init_ref(output ent_q_t q);
      q = {9'h121, 9'h1B1, 9'h104, 9'h114, 9'h120, 9'h10C};
   endtask

   task automatic frame_ref(output ent_q_t q);
      q = {9'h180, 9'h140};
      for (int i = 0; i < 504; i++) q.push_back({1'b0, mem[i]});
   endtask

   task automatic c_frame_ref(output ent_q_t q);
      q = {9'h180, 9'h140};
      for (int i = 0; i < 504; i++) q.push_back({1'b0, c_mem[i]});
   endtask

   task automatic cmp_stream(input string tag, input ent_q_t got, input ent_q_t expq, input bit exact);
      if (exact) check({tag, "_len"}, 32'(got.size()), 32'(expq.size()));
      else       check({tag, "_len"}, 32'(got.size() >= expq.size()), 32'd1);
      for (int i = 0; i < expq.size(); i++)
         if (i < got.size()) check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(expq[i]));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_en"},   32'(spi_enable), 32'd0);
      check({tag, "_data"}, 32'(spi_data),   32'h00);
      check({tag, "_mode"}, 32'(spi_mode),   32'd1);
      check({tag, "_busy"}, 32'(busy),       32'd1);
      check({tag, "_fd"},   32'(frame_done), 32'd0);
      check({tag, "_addr"}, 32'(fb_addr),    32'd0);
   endtask

   // Called on the negedge where nrst is released; first strobe expected 10 cycles later.
   task automatic first_enable(input string tag);
      int n = 0;
      do begin
         @(negedge clk); n++;
      end while (!spi_enable && n < 100);
      check(tag, 32'(n), 32'd10);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy && n < budget) begin @(negedge clk); n++; end
      check(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic wait_frames(input int nf, input int budget, input string tag);
      int n = 0;
      while ((fd_cnt < nf || busy) && n < budget) begin @(negedge clk); n++; end
      check(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   initial begin
      ent_q_t exp_q, f_q;
      int     k;

      nrst = 1'b1; c_nrst = 1'b1; refresh = 1'b0; spi_ready = 1'b1; c_ready = 1'b1;
      for (int i = 0; i < 512; i++) begin
         mem[i]   = 8'(i);
         c_mem[i] = 8'($urandom);
      end
      #1 nrst = 1'b0; c_nrst = 1'b0;
      #2 check_reset("rst0");

      // Power-up wait and init sequence
      repeat (3) @(negedge clk);
      nrst = 1'b1; c_nrst = 1'b1;
      first_enable("first_en_delay");
      wait_idle(2000, "init_idle");
      init_ref(exp_q);
      cmp_stream("init", log_q, exp_q, 1'b1);
      repeat (20) @(negedge clk);
      check("no_spont_frame", 32'(log_q.size()), 32'd6);

      // Frame with address-pattern memory
      log_q.delete(); fd_cnt = 0; addr_q.delete(); addr_track = 1'b1;
      pulse_refresh();
      wait_frames(1, 20000, "frame1_timeout");
      addr_track = 1'b0;
      frame_ref(exp_q);
      cmp_stream("frame1", log_q, exp_q, 1'b1);
      check("frame1_fd_cnt", 32'(fd_cnt), 32'd1);
      check("frame1_busy", 32'(busy), 32'd0);
      check("fb_addr_len", 32'(addr_q.size()), 32'd504);
      for (int i = 0; i < 504; i++)
         if (i < addr_q.size()) check($sformatf("fb_addr[%0d]", i), 32'(addr_q[i]), 32'(i));

      // refresh held during a frame, dropped before it ends: one frame only
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
      rand_lat = 1'b1; log_q.delete(); fd_cnt = 0;
      refresh = 1'b1;
      k = 0;
      while (log_q.size() < 100 && k < 5000) begin @(negedge clk); k++; end
      check("held_started", 32'(k < 5000), 32'd1);
      refresh = 1'b0;
      wait_frames(1, 20000, "held_timeout");
      repeat (50) @(negedge clk);
      check("held_fd_cnt", 32'(fd_cnt), 32'd1);
      frame_ref(exp_q);
      cmp_stream("held", log_q, exp_q, 1'b1);

      // refresh still high when the frame ends: exactly one more frame
      log_q.delete(); fd_cnt = 0;
      refresh = 1'b1;
      k = 0;
      while (fd_cnt < 1 && k < 20000) begin @(negedge clk); k++; end
      check("held2_first_done", 32'(k < 20000), 32'd1);
      k = 0;
      while (busy && k < 10) begin @(negedge clk); k++; end
      check("held2_idle_seen", 32'(k < 10), 32'd1);
      @(negedge clk);
      check("held2_restart", 32'(busy), 32'd1);
      refresh = 1'b0;
      wait_frames(2, 20000, "held2_timeout");
      repeat (50) @(negedge clk);
      check("held2_fd_cnt", 32'(fd_cnt), 32'd2);
      frame_ref(f_q);
      exp_q = {f_q, f_q};
      cmp_stream("held2", log_q, exp_q, 1'b1);

      // Serializer stall of 100 cycles mid-frame
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
      rand_lat = 1'b0; lat = 9; log_q.delete(); fd_cnt = 0;
      pulse_refresh();
      k = 0;
      while (log_q.size() < 300 && k < 20000) begin @(negedge clk); k++; end
      check("stall_reached", 32'(k < 20000), 32'd1);
      max_gap = 0;
      override = 100;
      wait_frames(1, 30000, "stall_timeout");
      check("stall_gap", 32'(max_gap >= 100), 32'd1);
      check("stall_fd_cnt", 32'(fd_cnt), 32'd1);
      frame_ref(exp_q);
      cmp_stream("stall", log_q, exp_q, 1'b1);

      // Reset while data byte 200 is in flight
      log_q.delete(); fd_cnt = 0;
      pulse_refresh();
      k = 0;
      while (log_q.size() < 203 && k < 20000) begin @(negedge clk); k++; end
      check("byte200_reached", 32'(k < 20000), 32'd1);
      #2 nrst = 1'b0;
      #1 check_reset("rst_mid");
      repeat (3) @(negedge clk);
      log_q.delete();
      nrst = 1'b1;
      first_enable("rst_first_en_delay");
      wait_idle(2000, "reinit_idle");
      init_ref(exp_q);
      cmp_stream("reinit", log_q, exp_q, 1'b1);
      check("rst_no_done", 32'(fd_cnt), 32'd0);

      // Continuous instance: back-to-back frames
      check("c_frames", 32'(c_fd_at.size() >= 3), 32'd1);
      for (int f = 0; f < 3; f++)
         if (f < c_fd_at.size())
            check($sformatf("c_done_at[%0d]", f), 32'(c_fd_at[f]), 32'(6 + 506 * (f + 1)));
      init_ref(exp_q);
      c_frame_ref(f_q);
      exp_q = {exp_q, f_q, f_q, f_q};
      cmp_stream("cont", c_log, exp_q, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
